// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: gray/binary conversion and almost-threshold sizing.
// Functions operate on PTR_MAX bits; callers zero-extend and truncate to their width.
package fifo_pkg;

  localparam int PTR_MAX = 32;

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs convert correctly because the leading zeros pass through unchanged.
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Quarter of the FIFO depth, where depth = 2^(width-1).
  function automatic int almost_threshold(input int width);
    return 1 << (width - 3);
  endfunction

endpackage

// File: rtl/write_pointer.sv
// Write-domain pointer and flag stage of the dual-clock FIFO.
// Registers the binary/gray write pointer pair plus full, almost_full, fill and sticky overflow.
module write_pointer
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             wclk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] rptr_sync,
  input  logic             overflow_clr,
  output logic [WIDTH-1:0] waddr,
  output logic [WIDTH-1:0] wptr,
  output logic             full,
  output logic             almost_full,
  output logic [WIDTH-1:0] wfill,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] DEPTH     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] THRESHOLD = WIDTH'(almost_threshold(WIDTH));

  logic             inc;
  logic [WIDTH-1:0] next_waddr;
  logic [WIDTH-1:0] next_wptr;
  logic [WIDTH-1:0] rbin;
  logic [WIDTH-1:0] next_fill;
  logic             next_full;
  logic             next_almost_full;

  always_comb begin
    inc              = wen && !full;
    next_waddr       = waddr + {{(WIDTH-1){1'b0}}, inc};
    next_wptr        = WIDTH'(bin2gray(PTR_MAX'(next_waddr)));
    rbin             = WIDTH'(gray2bin(PTR_MAX'(rptr_sync)));
    next_fill        = next_waddr - rbin;
    // Full when the write pointer is one lap ahead: top two gray bits inverted, rest equal.
    next_full        = (next_wptr == {~rptr_sync[WIDTH-1:WIDTH-2], rptr_sync[WIDTH-3:0]});
    next_almost_full = ((DEPTH - next_fill) <= THRESHOLD);
  end

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      waddr <= '0;
      wptr  <= '0;
    end else begin
      waddr <= next_waddr;
      wptr  <= next_wptr;
    end
  end

  // Set has priority over clear so a write lost in the clearing cycle is still reported.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
      wfill       <= '0;
      overflow    <= 1'b0;
    end else begin
      full        <= next_full;
      almost_full <= next_almost_full;
      wfill       <= next_fill;
      if (wen && full)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

endmodule
